// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: pixel-rate prescaler, h/v scan counters and a once-per-frame update-window FSM.
// Latency: pix_tick is registered one clk after the prescaler wraps; the counters step on the clk pix_tick is high; upd_grant is registered.
// Backpressure: none on the scan path; en=0 freezes the scan, and game logic closes the window with upd_done or loses it at frame wrap.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   en                    run enable (0 freezes prescaler, counters and frame number)
//   h_count, v_count      scan position, 0..HT-1 / 0..VT-1
//   pix_tick              one-clk pulse per pixel step
//   frame_tick            one-clk pulse at (HD, VD-1), the end of the visible frame
//   frame_num             8-bit frame counter, steps on frame_tick
//   upd_req/upd_done      update window handshake from game logic
//   upd_grant             update window open
//   overrun               sticky: a window was forcibly closed at frame wrap
module vga_scan_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int HD      = 640,
  parameter int HF      = 16,
  parameter int HR      = 96,
  parameter int HB      = 48,
  parameter int VD      = 480,
  parameter int VF      = 10,
  parameter int VR      = 2,
  parameter int VB      = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       pix_tick,
  output logic       frame_tick,
  output logic [7:0] frame_num,
  input  logic       upd_req,
  output logic       upd_grant,
  input  logic       upd_done,
  output logic       overrun
);

  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(HT - 1);
  localparam logic [9:0]    V_LAST   = 10'(VT - 1);
  localparam logic [9:0]    H_FRAME  = 10'(HD);
  localparam logic [9:0]    V_FRAME  = 10'(VD - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  logic [DW-1:0] div_q, div_d;
  logic          pix_q, pix_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [7:0]    fn_q, fn_d;
  logic          ovr_q, ovr_d;
  state_t        state_q, state_d;

  logic h_last, v_last, close_tick, ovr_set;

  // The pending tick is held while en=0 and only presented once scanning
  // resumes, so a freeze never drops or duplicates a pixel step.
  assign pix_tick   = pix_q & en;
  assign h_last     = (h_q == H_LAST);
  assign v_last     = (v_q == V_LAST);
  assign frame_tick = pix_tick & (h_q == H_FRAME) & (v_q == V_FRAME);
  // Pixel step that takes the counters back to (0,0): end of the window.
  assign close_tick = pix_tick & h_last & v_last;

  assign h_count   = h_q;
  assign v_count   = v_q;
  assign frame_num = fn_q;
  assign overrun   = ovr_q;

  // Prescaler and scan counters.
  always_comb begin
    div_d = div_q;
    pix_d = pix_q;
    h_d   = h_q;
    v_d   = v_q;
    fn_d  = fn_q;
    if (en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        pix_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
        pix_d = 1'b0;
      end
      if (pix_q) begin
        if (h_last) begin
          h_d = '0;
          v_d = v_last ? 10'd0 : v_q + 10'd1;
        end else begin
          h_d = h_q + 10'd1;
        end
      end
    end
    if (frame_tick) fn_d = fn_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      pix_q <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      fn_q  <= '0;
    end else begin
      div_q <= div_d;
      pix_q <= pix_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fn_q  <= fn_d;
    end
  end

  // Window FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovr_q   <= ovr_d;
    end
  end

  // Window FSM: next state. upd_done takes priority over the close tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_tick && upd_req) state_d = S_GRANT;
      S_GRANT: if (upd_done || close_tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Window FSM: outputs. upd_grant is a decode of the state flop only.
  always_comb begin
    upd_grant = (state_q == S_GRANT);
    ovr_set   = (state_q == S_GRANT) && !upd_done && close_tick;
    ovr_d     = ovr_q | ovr_set;
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
module tb_vga_scan_ctrl;

  // Reduced raster so several frames fit in a short run: HT=16, VT=10.
  localparam int D   = 4;
  localparam int HDp = 8, HFp = 2, HRp = 3, HBp = 3;
  localparam int VDp = 6, VFp = 1, VRp = 1, VBp = 2;
  localparam int HT  = HDp + HFp + HRp + HBp;
  localparam int VT  = VDp + VFp + VRp + VBp;
  localparam int FT  = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       upd_req = 1'b0;
  logic       upd_done = 1'b0;
  logic [9:0] h_count, v_count;
  logic       pix_tick, frame_tick, upd_grant, overrun;
  logic [7:0] frame_num;

  int checks = 0;
  int failures = 0;

  // Reference model: everything derives from the count of enabled clock edges.
  int       mk;
  bit       mgrant, movr;
  bit [7:0] mfn;

  vga_scan_ctrl #(
    .CLK_DIV(D), .HD(HDp), .HF(HFp), .HR(HRp), .HB(HBp),
    .VD(VDp), .VF(VFp), .VR(VRp), .VB(VBp)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .h_count(h_count), .v_count(v_count),
    .pix_tick(pix_tick), .frame_tick(frame_tick), .frame_num(frame_num),
    .upd_req(upd_req), .upd_grant(upd_grant), .upd_done(upd_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Pixel steps consumed so far: a tick is raised after every D-th enabled
  // edge and consumed on the following enabled edge.
  function automatic int m_pos();
    int p;
    p = (mk == 0) ? 0 : (mk - 1) / D;
    return p % FT;
  endfunction

  function automatic bit m_pix();
    return (mk > 0) && (mk % D == 0) && en;
  endfunction

  function automatic bit m_ft();
    return m_pix() && (m_pos() == (VDp - 1) * HT + HDp);
  endfunction

  function automatic bit m_wrap();
    return m_pix() && (m_pos() == FT - 1);
  endfunction

  task automatic check_model();
    logic [31:0] act, exp;
    act = {h_count, v_count, pix_tick, frame_tick, frame_num, upd_grant, overrun};
    exp = {10'(m_pos() % HT), 10'(m_pos() / HT), m_pix(), m_ft(), mfn, mgrant, movr};
    chk("model", act, exp);
  endtask

  // One clock: advance the model with the pre-edge inputs, then check.
  task automatic cyc();
    bit ft, wr;
    ft = m_ft();
    wr = m_wrap();
    if (!mgrant) begin
      if (ft && upd_req) mgrant = 1'b1;
    end else if (upd_done) begin
      mgrant = 1'b0;
    end else if (wr) begin
      mgrant = 1'b0;
      movr   = 1'b1;
    end
    if (ft) mfn = mfn + 8'd1;
    if (en) mk++;
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_async", {h_count, v_count, pix_tick, frame_tick, frame_num, upd_grant, overrun}, 32'd0);
    mk = 0; mgrant = 1'b0; movr = 1'b0; mfn = 8'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // sel 0: frame_tick; sel 1: the pixel step that wraps to (0,0).
  task automatic wait_for(input int sel, input string name);
    int n;
    n = 0;
    while (n < 2000) begin
      if (sel == 0 && frame_tick) return;
      if (sel == 1 && pix_tick && h_count == 10'(HT - 1) && v_count == 10'(VT - 1)) return;
      cyc();
      n++;
    end
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=none required=event", name);
  endtask

  typedef struct {
    bit en;
    int n;
    int h;
    int v;
    bit pix;
    bit ft;
    int fn;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1,   0,  0, 0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1,   4,  0, 0, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b1,   1,  1, 0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1,  59, 15, 0, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b1,   1,  0, 1, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0,  20,  0, 1, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1,   3,  0, 1, 1'b1, 1'b0, 0};
    tbl[7]  = '{1'b0,   5,  0, 1, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b1,   0,  0, 1, 1'b1, 1'b0, 0};
    tbl[9]  = '{1'b1,   1,  1, 1, 1'b0, 1'b0, 0};
    tbl[10] = '{1'b1, 287,  8, 5, 1'b1, 1'b1, 0};
    tbl[11] = '{1'b1,   1,  9, 5, 1'b0, 1'b0, 1};
    tbl[12] = '{1'b1, 283, 15, 9, 1'b1, 1'b0, 1};
    tbl[13] = '{1'b1,   1,  0, 0, 1'b0, 1'b0, 1};

    // Scan counters, prescaler, freeze and frame tick.
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en;
      repeat (tbl[i].n) cyc();
      #1;
      chk($sformatf("vec%0d", i),
          {h_count, v_count, pix_tick, frame_tick, frame_num},
          {10'(tbl[i].h), 10'(tbl[i].v), tbl[i].pix, tbl[i].ft, 8'(tbl[i].fn)});
    end

    // Window closed by upd_done.
    do_reset();
    en = 1'b1;
    upd_req = 1'b1;
    wait_for(0, "ft_a");
    chk("ft_pos", {h_count, v_count}, {10'(HDp), 10'(VDp - 1)});
    cyc();
    chk("grant_rise", {upd_grant, overrun}, 2'b10);
    upd_req = 1'b0;
    repeat (9) cyc();
    chk("grant_hold", upd_grant, 1'b1);
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    chk("grant_fall", {upd_grant, overrun}, 2'b00);

    // Window forced closed at frame wrap: overrun sticks.
    do_reset();
    en = 1'b1;
    upd_req = 1'b1;
    wait_for(0, "ft_b");
    cyc();
    wait_for(1, "close_b");
    chk("grant_before_close", upd_grant, 1'b1);
    cyc();
    chk("forced_close", {upd_grant, overrun, h_count, v_count}, {2'b01, 20'd0});
    upd_req = 1'b0;
    repeat (FT * D + 20) cyc();
    chk("overrun_sticky", overrun, 1'b1);

    // Reset mid-window clears everything before the next edge.
    upd_req = 1'b1;
    wait_for(0, "ft_c");
    cyc();
    chk("grant_before_reset", {upd_grant, overrun}, 2'b11);
    do_reset();

    // upd_done coinciding with the closing tick wins: no overrun.
    en = 1'b1;
    upd_req = 1'b1;
    wait_for(0, "ft_d");
    cyc();
    wait_for(1, "close_d");
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    chk("done_wins", {upd_grant, overrun}, 2'b00);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) upd_req = ~upd_req;
      upd_done = ($urandom_range(0, 149) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
